// File: rtl/reg_fd.sv
// Fetch-to-decode pipeline register: captures instruction, PC, PC+4 and fetch
// exception code, with stall, flush, eret nullify, delay-slot flag and a stall counter.
module reg_fd #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   En,
  input  logic                   Flush,
  input  logic                   eret,
  input  logic                   IsBranchD,
  input  logic [31:0]            InstrF,
  input  logic [31:0]            PCF,
  input  logic [31:0]            PC4F,
  input  logic [4:0]             ExcCodeF,
  input  logic                   CntClr,
  output logic [31:0]            InstrD,
  output logic [31:0]            PCD,
  output logic [31:0]            PC4D,
  output logic [4:0]             ExcCodeD,
  output logic                   BDD,
  output logic                   ValidD,
  output logic [STALL_CNT_W-1:0] StallCnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  // Flush wins over a stall; eret only nullifies when the pipe actually advances.
  logic bubble;
  logic stall_cnt_inc;

  assign bubble        = Flush | (En & eret);
  assign stall_cnt_inc = ~En & ~Flush & ValidD & (StallCnt != CNT_MAX);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      InstrD   <= '0;
      PCD      <= '0;
      PC4D     <= '0;
      ExcCodeD <= '0;
      BDD      <= 1'b0;
      ValidD   <= 1'b0;
      StallCnt <= '0;
    end else begin
      if (bubble) begin
        // A bubble still carries the PC so CP0 has something to report as EPC.
        InstrD   <= '0;
        PCD      <= PCF;
        PC4D     <= PC4F;
        ExcCodeD <= '0;
        BDD      <= 1'b0;
        ValidD   <= 1'b0;
      end else if (En) begin
        InstrD   <= InstrF;
        PCD      <= PCF;
        PC4D     <= PC4F;
        ExcCodeD <= ExcCodeF;
        BDD      <= IsBranchD;
        ValidD   <= 1'b1;
      end

      if (CntClr)
        StallCnt <= '0;
      else if (stall_cnt_inc)
        StallCnt <= StallCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_reg_fd.sv
// Directed table-driven bench for reg_fd plus a saturation sequence on a
// narrow-counter instance.
module tb_reg_fd;

  logic        Clk = 1'b0;
  logic        Reset, En, Flush, eret, IsBranchD, CntClr;
  logic [31:0] InstrF, PCF, PC4F;
  logic [4:0]  ExcCodeF;

  logic [31:0] InstrD, PCD, PC4D;
  logic [4:0]  ExcCodeD;
  logic        BDD, ValidD;
  logic [15:0] StallCnt;

  logic [31:0] s_InstrD, s_PCD, s_PC4D;
  logic [4:0]  s_ExcCodeD;
  logic        s_BDD, s_ValidD;
  logic [3:0]  s_StallCnt;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  reg_fd #(.STALL_CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Flush(Flush), .eret(eret),
    .IsBranchD(IsBranchD), .InstrF(InstrF), .PCF(PCF), .PC4F(PC4F),
    .ExcCodeF(ExcCodeF), .CntClr(CntClr),
    .InstrD(InstrD), .PCD(PCD), .PC4D(PC4D), .ExcCodeD(ExcCodeD),
    .BDD(BDD), .ValidD(ValidD), .StallCnt(StallCnt)
  );

  reg_fd #(.STALL_CNT_W(4)) u_sat (
    .Clk(Clk), .Reset(Reset), .En(En), .Flush(Flush), .eret(eret),
    .IsBranchD(IsBranchD), .InstrF(InstrF), .PCF(PCF), .PC4F(PC4F),
    .ExcCodeF(ExcCodeF), .CntClr(CntClr),
    .InstrD(s_InstrD), .PCD(s_PCD), .PC4D(s_PC4D), .ExcCodeD(s_ExcCodeD),
    .BDD(s_BDD), .ValidD(s_ValidD), .StallCnt(s_StallCnt)
  );

  typedef struct {
    logic        rst, en, fl, er, br, clr;
    logic [31:0] instr, pc;
    logic [4:0]  exc;
    logic [31:0] e_instr, e_pc;
    logic [4:0]  e_exc;
    logic        e_bd, e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, en, fl, er, br, clr,
    input logic [31:0] instr, pc, input logic [4:0] exc,
    input logic [31:0] e_instr, e_pc, input logic [4:0] e_exc,
    input logic e_bd, e_valid, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.er = er; v.br = br; v.clr = clr;
    v.instr = instr; v.pc = pc; v.exc = exc;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_exc = e_exc;
    v.e_bd = e_bd; v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, en, fl, er, br, clr,
                       input logic [31:0] instr, pc, input logic [4:0] exc);
    Reset = rst; En = en; Flush = fl; eret = er; IsBranchD = br; CntClr = clr;
    InstrF = instr; PCF = pc; PC4F = pc + 32'd4; ExcCodeF = exc;
  endtask

  localparam logic [31:0] I0 = 32'h2402_0001, I1 = 32'h2403_0002, I2 = 32'h0043_2020,
                          I3 = 32'h8c44_0000, I4 = 32'h1043_0004, I5 = 32'hac45_0004,
                          I6 = 32'h0000_000c, I7 = 32'h4200_0018, I8 = 32'h0800_0c00,
                          I9 = 32'h3c01_1234;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            rst en fl er br clr instr  pc           exc   e_instr e_pc        exc bd v  cnt
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, I0, 32'h3000, 0,   0,  32'h0,    0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, I0, 32'h3000, 0,   0,  32'h0,    0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, I0, 32'h3000, 0,   I0, 32'h3000, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, I1, 32'h3004, 0,   I1, 32'h3004, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, I2, 32'h3008, 0,   I2, 32'h3008, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, I1, 32'h3004, 0,   I1, 32'h3004, 0, 0, 1, 0));
    // three-cycle stall, then clear
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, I2, 32'h3008, 0,   I1, 32'h3004, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, I3, 32'h300c, 0,   I1, 32'h3004, 0, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, I4, 32'h3010, 0,   I1, 32'h3004, 0, 0, 1, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, I4, 32'h3010, 0,   I1, 32'h3004, 0, 0, 1, 0));
    // delay slot
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, I4, 32'h3010, 0,   I4, 32'h3010, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, I5, 32'h3014, 0,   I4, 32'h3010, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, I5, 32'h3014, 0,   I5, 32'h3014, 0, 0, 1, 1));
    // flush during stall, then holding a bubble does not count
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, I6, 32'h4180, 0,   0,  32'h4180, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, I7, 32'h3018, 0,   0,  32'h4180, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, I6, 32'h4180, 0,   I6, 32'h4180, 0, 0, 1, 1));
    // eret nullify, eret ignored while holding, flush+eret
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, I7, 32'h3020, 0,   0,  32'h3020, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, I8, 32'h3024, 0,   I8, 32'h3024, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, I9, 32'h3028, 0,   I8, 32'h3024, 0, 1, 1, 2));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, I9, 32'h4180, 0,   0,  32'h4180, 0, 0, 0, 2));
    // fetch exception loads as a valid instruction
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,  32'h2ffc, 4,   0,  32'h2ffc, 4, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, I9, 32'h3000, 0,   0,  32'h2ffc, 4, 0, 1, 3));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0,  32'h4180, 4,   0,  32'h4180, 0, 0, 0, 3));
    // reset mid-stall clears everything, counter included
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, I9, 32'h3030, 0,   I9, 32'h3030, 0, 0, 1, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, I0, 32'h3034, 0,   I9, 32'h3030, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, I0, 32'h3034, 0,   0,  32'h0,    0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, I0, 32'h3000, 0,   I0, 32'h3000, 0, 1, 1, 0));

    @(negedge Clk);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.en, v.fl, v.er, v.br, v.clr, v.instr, v.pc, v.exc);
      @(posedge Clk); #1;
      check($sformatf("v%0d InstrD", i),   InstrD,          v.e_instr);
      check($sformatf("v%0d PCD", i),      PCD,             v.e_pc);
      check($sformatf("v%0d PC4D", i),     PC4D,            (v.e_pc == 32'h0) ? 32'h0 : v.e_pc + 32'd4);
      check($sformatf("v%0d ExcCodeD", i), 32'(ExcCodeD),   32'(v.e_exc));
      check($sformatf("v%0d BDD", i),      32'(BDD),        32'(v.e_bd));
      check($sformatf("v%0d ValidD", i),   32'(ValidD),     32'(v.e_valid));
      check($sformatf("v%0d StallCnt", i), 32'(StallCnt),   32'(v.e_cnt));
      @(negedge Clk);
    end

    // saturation of the 4-bit counter across a 20-cycle stall
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1; @(negedge Clk);
    drive(1, 1, 0, 0, 0, 0, I3, 32'h3000, 0);
    @(posedge Clk); #1; @(negedge Clk);
    drive(1, 0, 0, 0, 0, 0, I4, 32'h3004, 0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      if (k == 14) check("sat k14", 32'(s_StallCnt), 32'd14);
      if (k == 15) check("sat k15", 32'(s_StallCnt), 32'd15);
      if (k == 16) check("sat k16 no wrap", 32'(s_StallCnt), 32'd15);
      if (k == 20) begin
        check("sat k20", 32'(s_StallCnt), 32'd15);
        check("wide k20", 32'(StallCnt), 32'd20);
        check("sat held PCD", s_PCD, 32'h3000);
        check("sat held InstrD", s_InstrD, I3);
      end
      @(negedge Clk);
    end
    drive(1, 0, 0, 0, 0, 1, I4, 32'h3004, 0);
    @(posedge Clk); #1;
    check("sat cleared", 32'(s_StallCnt), 32'd0);
    check("wide cleared", 32'(StallCnt), 32'd0);
    @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_fd.md
# reg_fd

Pipeline register between the fetch stage and the decode stage of the five-stage MIPS core. Captures the fetched instruction, PC, PC+4 and fetch exception code each cycle. Supports decode stall, interrupt/exception flush and eret nullification, and derives the branch-delay-slot flag that CP0 needs for EPC/Cause.BD. Also keeps a saturating stall-cycle counter for debug.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- Clk  in  1  core clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- En  in  1  1 = advance F→D; 0 = hold (decode stall from hazard unit)
- Flush  in  1  interrupt/exception entry; kill the instruction entering D
- eret  in  1  eret is in D this cycle
- IsBranchD  in  1  instruction now in D is a branch/jump (its successor is a delay slot)
- InstrF  in  32  fetched instruction (already zero when ExcCodeF ≠ 0)
- PCF  in  32  PC of fetched instruction
- PC4F  in  32  PCF + 4
- ExcCodeF  in  5  fetch exception code [6:2], 0 = none, 4 = AdEL
- CntClr  in  1  clear stall counter
- InstrD  out  32  instruction in D
- PCD  out  32  PC of instruction in D
- PC4D  out  32  PC+4 of instruction in D
- ExcCodeD  out  5  exception code carried into D
- BDD  out  1  instruction in D is in a delay slot
- ValidD  out  1  D holds a real instruction (0 = bubble)
- StallCnt  out  STALL_CNT_W  cycles in which a valid instruction was held

## Operation
- Per-cycle update priority, highest first: Reset, Flush, hold (En=0), eret nullify, load.
- Reset (Reset=0): InstrD=0, PCD=0, PC4D=0, ExcCodeD=0, BDD=0, ValidD=0, StallCnt=0.
- Flush: InstrD=0, ExcCodeD=0, BDD=0, ValidD=0. PCD is loaded with PCF and PC4D with PC4F, so a bubble still carries a PC for EPC. Flush overrides En=0.
- Hold (En=0, Flush=0): all data outputs keep their values. eret is ignored while holding, because the eret has not left D.
- eret nullify (En=1, eret=1): insert a bubble. InstrD=0, ExcCodeD=0, BDD=0, ValidD=0, PCD=PCF, PC4D=PC4F. eret has no delay slot.
- Load (En=1): InstrD=InstrF, PCD=PCF, PC4D=PC4F, ExcCodeD=ExcCodeF, BDD=IsBranchD, ValidD=1.
  - A fetch exception still loads with ValidD=1 and InstrD=0, so the exception reaches CP0.
- StallCnt:
  - CntClr=1 → 0. CntClr has priority over increment but not over Reset.
  - Otherwise +1 on a cycle with En=0, Flush=0 and ValidD=1.
  - Saturates at all-ones. No wrap.
- All outputs are driven directly from registers. No combinational path from inputs to outputs.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Stall of k cycles: outputs stay constant for k edges, and StallCnt increases by k (if ValidD=1).
- Flush and En=0 in the same cycle: flush wins; a bubble is visible after the edge.
- Flush and eret in the same cycle: flush wins; the result is the same bubble.
- IsBranchD sampled with En=1: the captured instruction gets BDD=1 and keeps it through any later stall.
- Reset mid-stall or mid-flush: reset values after the edge, including StallCnt.

## Test plan
- Reset then stream: hold Reset=0 for 2 cycles, then feed PCF=0x3000/0x3004/0x3008 with En=1 → all outputs 0 after reset; PCD=0x3000,0x3004,0x3008 on consecutive cycles, ValidD=1.
- Stall: En=0 for 3 cycles with PCD=0x3004 while PCF changes → PCD stays 0x3004, InstrD unchanged, StallCnt goes 0→3; CntClr=1 then gives StallCnt=0.
- Delay slot: IsBranchD=1 when loading PCF=0x3010; next cycle En=0 → BDD=1 held through the stall; the following load with IsBranchD=0 gives BDD=0.
- Flush during stall: En=0, Flush=1, PCF=0x4180 → ValidD=0, InstrD=0, PCD=0x4180, BDD=0.
- eret: eret=1 with En=1, PCF=0x3020 → bubble with ValidD=0, PCD=0x3020. eret=1 with En=0 → outputs held.
- Fetch exception: ExcCodeF=4, InstrF=0, PCF=0x2ffc, En=1 → ExcCodeD=4, ValidD=1, InstrD=0. StallCnt with STALL_CNT_W=4 saturates at 15 after 20 stall cycles.
